seq_mult_sm: RTL and testbench

- Parametrised, signed/unsigned, shift-add sequential multiplier with a start/busy/done handshake.
- Operands are DW-bit words, interpreted as two's complement or unsigned per request.
- Product is 2*DW bits, produced after a fixed DW+2 cycle latency.
- Sits between operand registers and the result/display path; it is the generalised engine behind the existing 8-bit multiplier datapath types.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult_abs.sv | 18 +
 rtl/seq_mult_sm.sv | 149 ++++++++++++++
 tb/tb_seq_mult_sm.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath family.
package mult_pkg;

   // Default operand width and the matching product width.
   localparam int DEF_DW  = 8;
   localparam int DEF_D2W = 2 * DEF_DW;

   // Fixed-width types used by the 8-bit multiplier datapath.
   typedef logic [DEF_DW-1:0]  data_t;
   typedef logic [DEF_D2W-1:0] product_t;

   // Sign/magnitude view of a two's complement operand.
   typedef struct packed {
      logic  sign;
      data_t mag;
   } comp2_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } mult_state_e;

endpackage

// File: rtl/mult_abs.sv
// Operand magnitude/sign split. In signed mode the most negative value maps
// to 2^(DW-1), which still fits in DW unsigned bits.
module mult_abs #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] x_i,
   input  logic          signed_i,
   output logic [DW-1:0] mag_o,
   output logic          neg_o
);

   // Negate only when the operand is signed and its msb is set.
   always_comb begin
      neg_o = signed_i & x_i[DW-1];
      mag_o = neg_o ? (DW'(0) - x_i) : x_i;
   end

endmodule

// File: rtl/seq_mult_sm.sv
// Shift-add sequential multiplier with start/busy/done handshake.
// Works on magnitudes and applies the final sign in a dedicated cycle, so the
// latency is a fixed DW+2 cycles regardless of operand values.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start_i; latches magnitudes and result sign
//   CALC  | one shift-add step per cycle, DW steps total
//   SIGN  | applies sign to accumulator, updates product_o/sign_o
//   DONE  | done_o pulse for one cycle, start_i ignored
module seq_mult_sm
   import mult_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            signed_i,
   input  logic            clear_i,
   input  logic [DW-1:0]   mltnd_i,
   input  logic [DW-1:0]   mlter_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [2*DW-1:0] product_o,
   output logic            sign_o
);

   localparam int CW = $clog2(DW + 1);
   localparam int PW = 2 * DW;

   mult_state_e   state_q,   state_d;
   logic [PW-1:0] acc_q,     acc_d;
   logic [PW-1:0] mltnd_q,   mltnd_d;
   logic [DW-1:0] mlter_q,   mlter_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic          neg_q,     neg_d;
   logic [PW-1:0] product_q, product_d;
   logic          sign_q,    sign_d;

   logic [DW-1:0] mag_a, mag_b;
   logic          neg_a, neg_b;

   mult_abs #(.DW(DW)) u_abs_mltnd (
      .x_i      (mltnd_i),
      .signed_i (signed_i),
      .mag_o    (mag_a),
      .neg_o    (neg_a)
   );

   mult_abs #(.DW(DW)) u_abs_mlter (
      .x_i      (mlter_i),
      .signed_i (signed_i),
      .mag_o    (mag_b),
      .neg_o    (neg_b)
   );

   // Next-state and datapath updates; clear_i overrides everything and leaves
   // the published result untouched.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mltnd_d   = mltnd_q;
      mlter_d   = mlter_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      product_d = product_q;
      sign_d    = sign_q;

      if (clear_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  mltnd_d = {{DW{1'b0}}, mag_a};
                  mlter_d = mag_b;
                  neg_d   = neg_a ^ neg_b;
                  acc_d   = '0;
                  // Down-counter: the step taken with cnt_q == 0 is the last.
                  cnt_d   = CW'(DW - 1);
                  state_d = CALC;
               end
            end
            CALC: begin
               if (mlter_q[0]) begin
                  acc_d = acc_q + mltnd_q;
               end
               mltnd_d = mltnd_q << 1;
               mlter_d = mlter_q >> 1;
               if (cnt_q == '0) begin
                  state_d = SIGN;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            SIGN: begin
               // A zero magnitude never reports as negative.
               if (acc_q == '0) begin
                  product_d = '0;
                  sign_d    = 1'b0;
               end else begin
                  product_d = neg_q ? (PW'(0) - acc_q) : acc_q;
                  sign_d    = neg_q;
               end
               state_d = DONE;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mltnd_q   <= '0;
         mlter_q   <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         sign_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mltnd_q   <= mltnd_d;
         mlter_q   <= mlter_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         product_q <= product_d;
         sign_q    <= sign_d;
      end
   end

   // Handshake outputs decoded straight from the state register.
   always_comb begin
      busy_o    = (state_q == CALC) || (state_q == SIGN);
      done_o    = (state_q == DONE);
      product_o = product_q;
      sign_o    = sign_q;
   end

endmodule

// File: tb/tb_seq_mult_sm.sv
// Bench for seq_mult_sm: three instances (DW = 4, 8, 16), directed table,
// handshake corner sequences and randomized operands vs. an arithmetic model.
module tb_seq_mult_sm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        sgn;
   logic        st4, st8, st16;
   logic [31:0] a_in, b_in;

   logic        busy4, done4, so4;
   logic [7:0]  p4;
   logic        busy8, done8, so8;
   logic [15:0] p8;
   logic        busy16, done16, so16;
   logic [31:0] p16;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   seq_mult_sm #(.DW(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start_i(st4), .signed_i(sgn), .clear_i(clr),
      .mltnd_i(a_in[3:0]), .mlter_i(b_in[3:0]),
      .busy_o(busy4), .done_o(done4), .product_o(p4), .sign_o(so4)
   );

   seq_mult_sm #(.DW(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start_i(st8), .signed_i(sgn), .clear_i(clr),
      .mltnd_i(a_in[7:0]), .mlter_i(b_in[7:0]),
      .busy_o(busy8), .done_o(done8), .product_o(p8), .sign_o(so8)
   );

   seq_mult_sm #(.DW(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start_i(st16), .signed_i(sgn), .clear_i(clr),
      .mltnd_i(a_in[15:0]), .mlter_i(b_in[15:0]),
      .busy_o(busy16), .done_o(done16), .product_o(p16), .sign_o(so16)
   );

   typedef struct {
      string       name;
      int          w;
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      logic        ps;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic sel_done(input int w);
      case (w)
         4:       return done4;
         8:       return done8;
         default: return done16;
      endcase
   endfunction

   function automatic logic sel_sign(input int w);
      case (w)
         4:       return so4;
         8:       return so8;
         default: return so16;
      endcase
   endfunction

   function automatic logic [63:0] sel_prod(input int w);
      case (w)
         4:       return {56'b0, p4};
         8:       return {48'b0, p8};
         default: return {32'b0, p16};
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         4:       st4 = v;
         8:       st8 = v;
         default: st16 = v;
      endcase
   endtask

   // Reference: interpret operands per mode, multiply, truncate to 2*w bits.
   task automatic model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output logic ps);
      longint av, bv, pr;
      av = longint'({32'b0, a});
      bv = longint'({32'b0, b});
      if (s && a[w-1]) av = av - (longint'(1) << w);
      if (s && b[w-1]) bv = bv - (longint'(1) << w);
      pr = av * bv;
      ps = s && (pr < 0);
      p  = 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
   endtask

   // One request on instance w; lat counts edges from acceptance to done_o.
   task automatic run_op(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output logic ps, output int lat);
      bit seen;
      @(negedge clk);
      sgn  = s;
      a_in = a;
      b_in = b;
      set_start(w, 1'b1);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         set_start(w, 1'b0);
         lat++;
         if (sel_done(w)) seen = 1'b1;
      end
      if (!seen) lat = -1;
      p  = sel_prod(w);
      ps = sel_sign(w);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] p, ep;
      logic        ps, eps;
      int          lat, ndone;
      logic [31:0] mask, ra, rb;
      bit          rs;
      int          widths[3];

      tbl[0]  = '{"u200x255", 8, 1'b0, 32'hC8,   32'hFF,   64'hC738,     1'b0};
      tbl[1]  = '{"s-128x-128", 8, 1'b1, 32'h80, 32'h80,   64'h4000,     1'b0};
      tbl[2]  = '{"s-128x127", 8, 1'b1, 32'h80,  32'h7F,   64'hC080,     1'b1};
      tbl[3]  = '{"s0x-5",    8, 1'b1, 32'h00,   32'hFB,   64'h0000,     1'b0};
      tbl[4]  = '{"s-1x-1",   8, 1'b1, 32'hFF,   32'hFF,   64'h0001,     1'b0};
      tbl[5]  = '{"s5x-3",    8, 1'b1, 32'h05,   32'hFD,   64'hFFF1,     1'b1};
      tbl[6]  = '{"u255x255", 8, 1'b0, 32'hFF,   32'hFF,   64'hFE01,     1'b0};
      tbl[7]  = '{"w4s-8x-8", 4, 1'b1, 32'h8,    32'h8,    64'h40,       1'b0};
      tbl[8]  = '{"w4s7x-8",  4, 1'b1, 32'h7,    32'h8,    64'hC8,       1'b1};
      tbl[9]  = '{"w16smin2", 16, 1'b1, 32'h8000, 32'h8000, 64'h40000000, 1'b0};
      tbl[10] = '{"w16umax2", 16, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, 1'b0};

      rst_n = 1'b0;
      clr   = 1'b0;
      sgn   = 1'b0;
      st4   = 1'b0;
      st8   = 1'b0;
      st16  = 1'b0;
      a_in  = '0;
      b_in  = '0;
      #1;
      check("rst_busy",  {63'b0, busy8}, 64'd0);
      check("rst_done",  {63'b0, done8}, 64'd0);
      check("rst_prod",  {48'b0, p8},    64'd0);
      check("rst_sign",  {63'b0, so8},   64'd0);
      check("rst_prod16", {32'b0, p16},  64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 11; i++) begin
         run_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, p, ps, lat);
         check({tbl[i].name, "_prod"}, p, tbl[i].p);
         check({tbl[i].name, "_sign"}, {63'b0, ps}, {63'b0, tbl[i].ps});
         check({tbl[i].name, "_lat"},  64'(lat), 64'(tbl[i].w + 2));
      end

      // Busy handling: a second start during CALC is dropped.
      @(negedge clk);
      sgn = 1'b0; a_in = 32'd3; b_in = 32'd4; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      check("busy_high", {63'b0, busy8}, 64'd1);
      @(negedge clk);
      a_in = 32'd9; b_in = 32'd9; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; a_in = '0; b_in = '0;
      ndone = 0;
      p = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done8) begin
            ndone++;
            if (ndone == 1) p = {48'b0, p8};
         end
      end
      check("busy_done_count", 64'(ndone), 64'd1);
      check("busy_prod", p, 64'd12);

      // Clear on the 4th CALC cycle of 7 x 7.
      @(negedge clk);
      a_in = 32'd7; b_in = 32'd7; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_busy", {63'b0, busy8}, 64'd0);
      check("clr_done", {63'b0, done8}, 64'd0);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check("clr_no_done", 64'(ndone), 64'd0);
      check("clr_prod_held", {48'b0, p8}, 64'd12);
      run_op(8, 1'b0, 32'd2, 32'd3, p, ps, lat);
      check("after_clr_prod", p, 64'd6);
      run_op(8, 1'b0, 32'd9, 32'd9, p, ps, lat);
      check("after_busy_prod", p, 64'd81);

      // Clear together with start in IDLE: start is dropped.
      @(negedge clk);
      a_in = 32'd5; b_in = 32'd5; st8 = 1'b1; clr = 1'b1;
      @(negedge clk);
      st8 = 1'b0; clr = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done8 || busy8) ndone++;
      end
      check("clr_start_dropped", 64'(ndone), 64'd0);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      sgn = 1'b1; a_in = 32'd7; b_in = 32'd7; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {63'b0, busy8}, 64'd0);
      check("arst_done", {63'b0, done8}, 64'd0);
      check("arst_prod", {48'b0, p8},    64'd0);
      check("arst_sign", {63'b0, so8},   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8, 1'b1, 32'h05, 32'hFD, p, ps, lat);
      check("arst_after_prod", p, 64'hFFF1);
      check("arst_after_sign", {63'b0, ps}, 64'd1);

      // Randomized operands on every width.
      widths[0] = 4;
      widths[1] = 8;
      widths[2] = 16;
      for (int k = 0; k < 3; k++) begin
         mask = (32'd1 << widths[k]) - 32'd1;
         for (int i = 0; i < 30; i++) begin
            ra = $urandom() & mask;
            rb = $urandom() & mask;
            rs = 1'($urandom_range(0, 1));
            model(widths[k], rs, ra, rb, ep, eps);
            run_op(widths[k], rs, ra, rb, p, ps, lat);
            check($sformatf("rnd_w%0d_prod_%0h_%0h_s%0d", widths[k], ra, rb, rs), p, ep);
            check($sformatf("rnd_w%0d_sign", widths[k]), {63'b0, ps}, {63'b0, eps});
            check($sformatf("rnd_w%0d_lat", widths[k]), 64'(lat), 64'(widths[k] + 2));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
